// File: rtl/fetch_queue_pkg.sv
// Pipeline-wide defaults shared by IF, the fetch queue and ID.
package fetch_queue_pkg;

  localparam int          PIPE_XLEN      = 32;
  localparam logic [31:0] PIPE_NOP_WORD  = 32'h0000_0000;
  localparam logic [31:0] PIPE_HALT_WORD = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [PIPE_XLEN-1:0] pcplus4;
    logic [PIPE_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fq_storage.sv
// Entry array for the fetch queue: one write port, asynchronous read, no reset on contents.
// Latency: write lands on the clock edge; read is combinational. No backpressure of its own.
module fq_storage #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [WIDTH-1:0]           rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// IF->ID fetch queue: circular FIFO of {PC+4, instr} with flush and halt handling.
// Latency: push visible one cycle later (no bypass). Backpressure: push_ready low when full (without pop), halted, flushing or in reset.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              XLEN      = PIPE_XLEN,
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] NOP_WORD  = XLEN'(PIPE_NOP_WORD),
  parameter logic [XLEN-1:0] HALT_WORD = XLEN'(PIPE_HALT_WORD)
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     push_valid,
  input  logic [XLEN-1:0]          push_pcplus4,
  input  logic [XLEN-1:0]          push_instr,
  output logic                     push_ready,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_pcplus4,
  output logic [XLEN-1:0]          out_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     halt_pending,
  output logic                     stop
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 halt_latched;
  logic                 full, empty;
  logic                 push_fire, pop_fire;
  logic [2*XLEN-1:0]    head_dat;
  logic [XLEN-1:0]      head_pcplus4, head_instr;

  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = count[AW];

  assign out_valid    = !Reset && !empty;
  assign out_pcplus4  = out_valid ? head_pcplus4 : '0;
  assign out_instr    = out_valid ? head_instr : NOP_WORD;
  assign halt_pending = out_valid && halt_latched;

  assign push_ready = !Reset && !flush && !halt_latched && (!full || pop);
  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = pop && out_valid && !flush;

  fq_storage #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_storage (
    .clk     (clk),
    .wr_en   (push_fire),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data ({push_pcplus4, push_instr}),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (head_dat)
  );

  assign {head_pcplus4, head_instr} = head_dat;

  always_ff @(posedge clk) begin
    if (Reset || flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      halt_latched <= 1'b0;
      stop         <= 1'b0;
    end else begin
      if (push_fire) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
        if (push_instr == HALT_WORD) halt_latched <= 1'b1;
      end
      if (pop_fire) rd_ptr <= rd_ptr + (AW+1)'(1);
      stop <= pop_fire && (head_instr == HALT_WORD);
    end
  end

endmodule
